ioctl_upload_reader: RTL and testbench



---
 rtl/ioctl_upload_reader.sv | 97 +++++++++
 tb/tb_ioctl_upload_reader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves upload bytes from a toggle-handshake 16-bit memory port to data_io.
// Define UPLOAD_CHECKSUM_EN to accumulate an 8-bit sum of consumed bytes on checksum.
module ioctl_upload_reader #(
    parameter logic [21:0] BASE_ADDR = 22'h0,
    parameter logic [15:0] LENGTH    = 16'd1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [21:0] mem_a,
    input  logic [15:0] mem_q,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [7:0]  checksum
);
    typedef enum logic [1:0] {IDLE, FETCH, READY, DONE} state_t;
    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  hi;
    logic [15:0] cnt_next;
    logic        port_idle;
    assign cnt_next  = cnt + 16'd1;
    assign port_idle = mem_ack == mem_req;
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            ioctl_din <= '0;
            mem_req   <= 1'b0;
            mem_a     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else if (!ioctl_upload) begin
            // an outstanding request is left to complete; IDLE waits for its ack
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ioctl_rd) overrun <= 1'b1;
                    if (port_idle) begin
                        cnt     <= '0;
                        overrun <= 1'b0;
                        mem_a   <= BASE_ADDR;
                        mem_req <= ~mem_req;
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (ioctl_rd) overrun <= 1'b1;
                    if (port_idle) begin
                        hi        <= mem_q[15:8];
                        ioctl_din <= cnt[0] ? mem_q[15:8] : mem_q[7:0];
                        busy      <= 1'b0;
                        state     <= READY;
                    end
                end
                READY: begin
                    if (ioctl_rd) begin
                        cnt <= cnt_next;
                        if (cnt_next == LENGTH) begin
                            ioctl_din <= 8'hFF;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (!cnt[0]) begin
                            ioctl_din <= hi;
                        end else begin
                            mem_a   <= BASE_ADDR + {7'd0, cnt_next[15:1]};
                            mem_req <= ~mem_req;
                            busy    <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`ifdef UPLOAD_CHECKSUM_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) checksum <= '0;
        else if (ioctl_upload && state == IDLE && port_idle) checksum <= '0;
        else if (ioctl_upload && state == READY && ioctl_rd) checksum <= checksum + ioctl_din;
    end
`else
    assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb_ioctl_upload_reader: directed checks of ioctl_upload_reader against a 3-cycle toggle memory.
module tb_ioctl_upload_reader;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [7:0]  ioctl_din;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [21:0] mem_a;
    logic [15:0] mem_q = 16'h0;
    logic        busy, done, overrun;
    logic [7:0]  checksum;
    logic        hold = 1'b0;
    logic [1:0]  lat = 2'd0;
    logic        req_q = 1'b0;
    int          toggles = 0;
    int          checks = 0;
    int          errors = 0;
    int          t0;
    logic [7:0]  sum_exp;

    ioctl_upload_reader #(.BASE_ADDR(22'h100), .LENGTH(16'd4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_din(ioctl_din), .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a),
        .mem_q(mem_q), .busy(busy), .done(done), .overrun(overrun), .checksum(checksum)
    );

    always #5 clk_sys = ~clk_sys;

    // memory: acks 3 cycles after a request toggle unless held
    always @(posedge clk_sys) begin
        if (mem_req != mem_ack && !hold) begin
            if (lat == 2'd2) begin
                mem_ack <= mem_req;
                mem_q   <= mem_a == 22'h100 ? 16'hBBAA : mem_a == 22'h101 ? 16'hDDCC : 16'h0000;
                lat     <= 2'd0;
            end else lat <= lat + 2'd1;
        end
        req_q <= mem_req;
        if (mem_req != req_q) toggles <= toggles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd();
        ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!busy && n < 30) begin @(negedge clk_sys); n++; end
        while (busy && n < 60) begin @(negedge clk_sys); n++; end
        chk("ready_timeout", 32'(n < 60), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef UPLOAD_CHECKSUM_EN
        sum_exp = 8'h0E;
`else
        sum_exp = 8'h00;
`endif
        repeat (2) @(negedge clk_sys);
        chk("rst_outs", {mem_req, busy, done, overrun, ioctl_din, checksum}, 32'h0);
        chk("rst_mem_a", 32'(mem_a), 32'h0);
        reset = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("start_req", {mem_req, busy}, 32'h3);
        chk("start_addr", 32'(mem_a), 32'h100);
        wait_ready();
        chk("byte0", 32'(ioctl_din), 32'hAA);
        rd();
        chk("byte1", 32'(ioctl_din), 32'hBB);
        chk("even_odd_noreq", {mem_req, busy}, 32'h2);
        chk("one_toggle", 32'(toggles), 32'd1);
        rd();
        chk("odd_fetch_busy", {mem_req, busy}, 32'h1);
        chk("odd_fetch_addr", 32'(mem_a), 32'h101);
        wait_ready();
        chk("byte2", 32'(ioctl_din), 32'hCC);
        chk("two_toggles", 32'(toggles), 32'd2);
        rd();
        chk("byte3", 32'(ioctl_din), 32'hDD);
        rd();
        chk("done", {done, overrun}, 32'h2);
        chk("done_din", 32'(ioctl_din), 32'hFF);
        chk("checksum", 32'(checksum), 32'(sum_exp));
        rd();
        repeat (4) @(negedge clk_sys);
        chk("done_ignores_rd", {done, overrun, ioctl_din}, 32'h2FF);
        chk("done_no_req", 32'(toggles), 32'd2);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        chk("done_clears", 32'(done), 32'd0);
        chk("checksum_held", 32'(checksum), 32'(sum_exp));

        // read strobe while fetching
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("restart_busy", 32'(busy), 32'd1);
        rd();
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_ready();
        chk("overrun_no_adv", 32'(ioctl_din), 32'hAA);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("overrun_cleared", {overrun, busy}, 32'h1);
        chk("checksum_cleared", 32'(checksum), 32'h0);
        wait_ready();

        // upload dropped and re-raised while a request is outstanding
        hold = 1'b1;
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
        t0 = toggles;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("held_fetch", 32'(busy), 32'd1);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        repeat (6) @(negedge clk_sys);
        chk("no_new_toggle", 32'(toggles - t0), 32'd1);
        chk("waiting_idle", 32'(busy), 32'd0);
        hold = 1'b0;
        wait_ready();
        @(negedge clk_sys);
        chk("retoggle_once", 32'(toggles - t0), 32'd2);
        chk("restart_byte0", 32'(ioctl_din), 32'hAA);
        chk("restart_addr", 32'(mem_a), 32'h100);

        // asynchronous reset mid-fetch
        rd();
        rd();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outs", {mem_req, busy, done, overrun, ioctl_din, checksum}, 32'h0);
        chk("async_rst_mem_a", 32'(mem_a), 32'h0);
        @(negedge clk_sys);
        reset = 1'b0;
        wait_ready();
        chk("post_reset_byte0", 32'(ioctl_din), 32'hAA);
        chk("post_reset_addr", 32'(mem_a), 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
